// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive monitor.
// Optional macro UART_RX_PARITY_EN adds the even-parity state.
package uart_rx_pkg;

   localparam int DEF_CLK_FREQ_HZ = 100_000_000;
   localparam int DEF_BAUD        = 115_200;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Power-of-two byte FIFO with valid/ready pop; a pop frees space before a same-cycle push.
// Unaffected by UART_RX_PARITY_EN.
module uart_rx_fifo
   import uart_rx_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic [7:0] push_data_i,
   input  logic       pop_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       drop_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full;
   logic          pop_ok;
   logic          push_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign valid_o = (count_q != '0);
   assign pop_ok  = pop_i & valid_o;
   assign push_ok = push_i & (~full | pop_ok);
   assign drop_o  = push_i & ~push_ok;
   // Head is forced to zero when empty so the output is defined from reset.
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : 8'h00;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a byte FIFO,
// with sticky frame-error and overrun flags.
module uart_rx_monitor
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
   parameter int BAUD        = DEF_BAUD,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       io_clock,
   input  logic       io_reset,
   input  logic       io_rxd,
   output logic [7:0] io_data,
   output logic       io_valid,
   input  logic       io_ready,
   output logic       io_frameError,
   output logic       io_overrun,
   input  logic       io_clearErrors
);

   localparam int DIV = CLK_FREQ_HZ / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

   logic          rxd_s1_q, rxd_s2_q;
   logic [1:0]    flush_q;
   logic          armed_q, armed_d;
   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          brk_wait_q, brk_wait_d;
   logic          push_q, push_d;
   logic [7:0]    push_data_q, push_data_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          frame_set;
   logic          tick;
   logic          fifo_drop;
`ifdef UART_RX_PARITY_EN
   logic          par_bad_q, par_bad_d;
`endif

   assign tick = (cnt_q == '0);

   // armed_q only rises once the synchronizer holds a real high level, so a line
   // held low through reset cannot look like a start edge afterwards.
   assign armed_d = armed_q | (flush_q[1] & rxd_s2_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      brk_wait_d  = brk_wait_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      frame_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d   = par_bad_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (armed_q && !rxd_s2_q) begin
               state_d = ST_START;
               cnt_d   = CNT_HALF;
            end
         end
         ST_START: begin
            if (!tick) begin
               cnt_d = cnt_q - CW'(1);
            end else if (!rxd_s2_q) begin
               state_d   = ST_DATA;
               cnt_d     = CNT_FULL;
               bit_idx_d = 3'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (!tick) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               shift_d = {rxd_s2_q, shift_q[7:1]};
               cnt_d   = CNT_FULL;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (!tick) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               par_bad_d = ^{shift_q, rxd_s2_q};
               cnt_d     = CNT_FULL;
               state_d   = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (brk_wait_q) begin
               if (rxd_s2_q) begin
                  brk_wait_d = 1'b0;
                  state_d    = ST_IDLE;
               end
            end else if (!tick) begin
               cnt_d = cnt_q - CW'(1);
            end else if (rxd_s2_q) begin
               state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
               if (par_bad_q) begin
                  frame_set = 1'b1;
               end else begin
                  push_d      = 1'b1;
                  push_data_d = shift_q;
               end
`else
               push_d      = 1'b1;
               push_data_d = shift_q;
`endif
            end else begin
               frame_set  = 1'b1;
               brk_wait_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Setting a flag wins over a same-cycle clear.
   assign frame_err_d = (frame_err_q & ~io_clearErrors) | frame_set;
   assign overrun_d   = (overrun_q & ~io_clearErrors) | fifo_drop;

   always_ff @(posedge io_clock) begin
      if (io_reset) begin
         rxd_s1_q    <= 1'b1;
         rxd_s2_q    <= 1'b1;
         flush_q     <= 2'b00;
         armed_q     <= 1'b0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         brk_wait_q  <= 1'b0;
         push_q      <= 1'b0;
         push_data_q <= 8'h00;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rxd_s1_q    <= io_rxd;
         rxd_s2_q    <= rxd_s1_q;
         flush_q     <= {flush_q[0], 1'b1};
         armed_q     <= armed_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         brk_wait_q  <= brk_wait_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge io_clock) begin
      if (io_reset) begin
         par_bad_q <= 1'b0;
      end else begin
         par_bad_q <= par_bad_d;
      end
   end
`endif

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (io_clock),
      .rst_i       (io_reset),
      .push_i      (push_q),
      .push_data_i (push_data_q),
      .pop_i       (io_ready),
      .data_o      (io_data),
      .valid_o     (io_valid),
      .drop_o      (fifo_drop)
   );

   assign io_frameError = frame_err_q;
   assign io_overrun    = overrun_q;

endmodule

// File: doc/uart_rx_monitor.md
UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100000000, SHALL be the io_clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, SHALL be the serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL be the receive buffer depth in bytes; it is a power of two and at least 2.
REQ-004 io_clock  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 io_reset  input  1  SHALL be the reset; it is synchronous and active-high.
REQ-006 io_rxd  input  1  SHALL be the asynchronous serial line; it idles high and is fed by a top-level txd such as io_uartStd_txd.
REQ-007 io_data  output  8  SHALL be the received byte at the FIFO head.
REQ-008 io_valid  output  1  SHALL be high while the FIFO is non-empty.
REQ-009 io_ready  input  1  SHALL be the consumer accept; a pop occurs when io_valid and io_ready are both high at a clock edge.
REQ-010 io_frameError  output  1  SHALL be a sticky flag indicating a stop bit was sampled low.
REQ-011 io_overrun  output  1  SHALL be a sticky flag indicating a byte was dropped because the FIFO was full.
REQ-012 io_clearErrors  input  1  SHALL clear both sticky flags on the next edge.

Function
REQ-013 io_rxd SHALL pass through a 2-flop synchronizer initialised to 1 before any use.
REQ-014 DIV = CLK_FREQ_HZ/BAUD (integer division; 868 at the defaults); the bit counter SHALL be $clog2(DIV) bits wide and count 0..DIV-1.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-016 IDLE->START SHALL occur on a synchronized falling edge, with the counter loaded so the next sample falls at DIV/2 cycles.
REQ-017 START: a low sample at mid-bit SHALL lead to DATA; a high sample SHALL return to IDLE with no byte and no error.
REQ-018 DATA: the FSM SHALL take 8 samples, each DIV cycles apart, shifted LSB first, then go to STOP (or PARITY).
REQ-019 STOP: a high mid-bit sample SHALL push the byte, or set io_overrun and drop it if the FIFO is full; a low sample SHALL set io_frameError, drop the byte and return to IDLE only once the line is high.
REQ-020 Push latency SHALL be io_valid high 1 cycle after the stop-bit sample edge when the FIFO was empty.
REQ-021 A push and a pop in the same cycle on a full FIFO SHALL both succeed with no overrun, because the pop frees space first.
REQ-022 A push and a pop in the same cycle on an empty FIFO SHALL leave io_valid high and present the new byte.
REQ-023 io_data SHALL be stable while io_valid is high and io_ready is low.
REQ-024 If io_clearErrors and a new error occur in the same cycle, the set SHALL win.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an explicit count of $clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-026 On io_reset the FSM SHALL go to IDLE, the FIFO shall empty, and the synchronizer shall be set to 1; io_valid, io_frameError and io_overrun SHALL be 0, and io_data SHALL be 8'h00.
REQ-027 Reset asserted mid-frame SHALL abort the frame, push no byte and flag no error.
REQ-028 After reset deassertion, reception SHALL begin only after a falling edge; a line held low during reset SHALL NOT start a frame.

Configuration
REQ-029 Macro UART_RX_PARITY_EN SHALL, when defined, add an even-parity bit between DATA and STOP.
REQ-030 With UART_RX_PARITY_EN, a parity mismatch SHALL drop the byte and set io_frameError.
REQ-031 Without UART_RX_PARITY_EN, the PARITY state and the parity logic SHALL be absent and the frame is 8N1.

Structure
REQ-032 Package uart_rx_pkg SHALL hold the FSM state enum typedef and the default CLK_FREQ_HZ and BAUD constants.
REQ-033 Sub-module uart_rx_fifo SHALL implement the parameterised valid/ready byte FIFO.

Verification
REQ-034 Defaults: send 0x55 8N1 with io_ready=1 -> io_data=0x55 with io_valid high for 1 cycle, both flags 0.
REQ-035 Send a 12-cycle low glitch on io_rxd -> no io_valid, no error.
REQ-036 Send bytes 0x01..0x05 with io_ready=0 -> 0x01..0x04 buffered, io_overrun=1; draining yields 0x01,0x02,0x03,0x04 in order.
REQ-037 Send 0xA5 with the stop bit forced low -> io_frameError=1, no io_valid; pulse io_clearErrors -> flag returns to 0.
REQ-038 Assert io_reset during data bit 4 of 0xFF, then send 0x3C -> only 0x3C is received.
REQ-039 With UART_RX_PARITY_EN, send 0x03 with the parity bit set to 1 -> io_frameError=1 and the byte dropped; send it with parity 0 -> 0x03 accepted.
